pcxt_clock_reset_ctrl: RTL
==========================

// Module: pcxt_clock_reset_ctrl
// PURPOSE
//  Single-clock clock/reset controller for the PCXT core. Derives CPU and peripheral clocks (1-clock-wide levels
//  plus enables), selectable 4.77/7.16/14.318 MHz CPU speed, splash timer, and chained system/CPU reset sequencing.
//  Also provides N asynchronous-input edge detectors (OPL2, UART, ...). Sits between the top level and CHIPSET/i8088.
// PARAMETERS
//  PRE_DIV          4         clock cycles per base tick (tick rate = 28.636 MHz); minimum 1
//  RESET_CYCLES     65535     clock cycles reset_out stays high after reset_n/splash release; minimum 1
//  CPU_RESET_DELAY  42        clock cycles from reset_out low to reset_cpu low
//  TICKS_PER_SEC    28636000  base ticks per splash second
//  SPLASH_SECONDS   5         splash duration in seconds; 0 = no splash
//  NUM_SYNC         2         number of async edge-detect channels; minimum 1
// PORTS
//  clock         in   1         chipset clock; everything sampled on posedge
//  reset_n       in   1         asynchronous active-low reset
//  speed_sel     in   2         0=4.77, 1=7.16, 2=14.318 MHz, 3=reserved (treated as 0)
//  biu_done      in   1         CPU BIU idle; speed change and turbo_mode update are allowed only when high
//  splash_skip   in   1         level; ends splash at the next tick
//  async_in      in   NUM_SYNC  asynchronous square waves
//  cpu_clk       out  1         CPU clock level
//  cpu_clk_rise  out  1         1-cycle pulse on cpu_clk 0->1
//  pclk          out  1         peripheral clock = 4.77 MHz / 2
//  turbo_mode    out  1         high while the active speed is not 4.77 MHz
//  splashscreen  out  1         splash active
//  reset_out     out  1         system reset, active high
//  reset_cpu     out  1         CPU reset, active high
//  sync_rise     out  NUM_SYNC  1-cycle pulse per async_in rising edge
// BEHAVIOUR
//  Reset values (reset_n=0): cpu_clk=0, cpu_clk_rise=0, pclk=0, turbo_mode=0, splashscreen=1 (0 if SPLASH_SECONDS=0),
//   reset_out=1, reset_cpu=1, sync_rise=0, active speed=4.77, all counters=0.
//  Prescaler: modulo-PRE_DIV counter; tick=1 when count==PRE_DIV-1.
//  CPU phase counter advances on tick. Period and high time in ticks: 4.77: 6 and 2 (33% duty); 7.16: 4 and 2;
//   14.318: 2 and 1. cpu_clk=1 while phase<high; cpu_clk_rise on the clock where cpu_clk goes 0->1.
//  Speed change: speed_sel is sampled only when phase wraps to 0 and biu_done=1. It then becomes the active speed
//   and turbo_mode updates in the same cycle. No runt pulses: high time is never truncated.
//  pclk: independent 12-tick counter, high for ticks 0-5; never affected by speed_sel.
//  Splash: counts ticks to TICKS_PER_SEC, then increments a seconds counter. splashscreen falls when
//   seconds==SPLASH_SECONDS or when splash_skip=1 on a tick. splashscreen is sticky low until reset_n.
//  Reset FSM: S_SPLASH -> S_SYS -> S_CPU -> S_RUN.
//   S_SPLASH: both resets=1.
//   S_SYS: count RESET_CYCLES clocks, then reset_out=0.
//   S_CPU: count CPU_RESET_DELAY clocks, then reset_cpu=0.
//   S_RUN: terminal state.
//   reset_n low in any state returns the FSM to S_SPLASH asynchronously.
//  sync_rise[i]: 3-flop synchroniser; pulse = ff2 & ~ff3, giving 3-clock latency from the async edge.
//   Input pulses shorter than 2 clocks may be lost; that is permitted.
//  Counters saturate or wrap exactly at their terminal values; no overflow beyond the stated widths.
// CONFIGURATION
//  PCXT_SPLASH_EN defined: splash timer and S_SPLASH behave as above.
//  PCXT_SPLASH_EN undefined: splash logic is not built; splashscreen=0 constant; FSM starts in S_SYS;
//   splash_skip is ignored.
// STRUCTURE
//  Package pcxt_clk_pkg: speed_t enum (SPD_477, SPD_716, SPD_1431); per-speed period/high constants;
//   rst_state_t enum.
//  Sub-module pcxt_edge_sync: 1-bit 3-flop synchroniser plus rise detector, instantiated NUM_SYNC times via generate.
// TESTING
//  1 reset_n low->high, speed_sel=0, PRE_DIV=1 -> cpu_clk period 6 clocks, high 2; pclk period 12, high 6;
//    turbo_mode=0.
//  2 speed_sel 0->2 with biu_done=0 -> speed unchanged; raise biu_done -> switch at the next phase wrap,
//    period becomes 2, turbo_mode=1, no high pulse shorter than 1 tick.
//  3 SPLASH_SECONDS=2, TICKS_PER_SEC=10, PRE_DIV=1 -> splashscreen falls at clock 20; reset_out falls
//    RESET_CYCLES later; reset_cpu falls a further 42 clocks later.
//  4 splash_skip pulsed at clock 5 -> splashscreen=0 at clock 5 or 6; reset sequence starts immediately.
//  5 reset_n pulsed low during S_CPU -> reset_out=1 and reset_cpu=1 immediately, sequence restarts from S_SPLASH.
//  6 async_in[1] square wave, period 7 clocks -> exactly one sync_rise[1] pulse per period, 3 clocks after
//    each edge; build without PCXT_SPLASH_EN -> splashscreen never 1.

Source files
------------

// File: rtl/pcxt_clk_pkg.sv
// Shared types and per-speed timing constants for the PCXT clock/reset controller.
package pcxt_clk_pkg;

   localparam int unsigned PHASE_W   = 3;
   localparam int unsigned PCLK_W    = 4;
   localparam int unsigned PCLK_LAST = 11;
   localparam int unsigned PCLK_HIGH = 6;

   typedef enum logic [1:0] {
      SPD_477  = 2'd0,
      SPD_716  = 2'd1,
      SPD_1431 = 2'd2
   } speed_t;

   typedef enum logic [1:0] {
      S_SPLASH = 2'd0,
      S_SYS    = 2'd1,
      S_CPU    = 2'd2,
      S_RUN    = 2'd3
   } rst_state_t;

   // Last phase index and high time, both in base ticks
   localparam logic [PHASE_W-1:0] LAST_477  = 3'd5;
   localparam logic [PHASE_W-1:0] HIGH_477  = 3'd2;
   localparam logic [PHASE_W-1:0] LAST_716  = 3'd3;
   localparam logic [PHASE_W-1:0] HIGH_716  = 3'd2;
   localparam logic [PHASE_W-1:0] LAST_1431 = 3'd1;
   localparam logic [PHASE_W-1:0] HIGH_1431 = 3'd1;

   function automatic speed_t decode_speed(input logic [1:0] sel);
      case (sel)
         2'd1:    return SPD_716;
         2'd2:    return SPD_1431;
         default: return SPD_477;
      endcase
   endfunction

   function automatic logic [PHASE_W-1:0] speed_last(input speed_t s);
      case (s)
         SPD_716:  return LAST_716;
         SPD_1431: return LAST_1431;
         default:  return LAST_477;
      endcase
   endfunction

   function automatic logic [PHASE_W-1:0] speed_high(input speed_t s);
      case (s)
         SPD_716:  return HIGH_716;
         SPD_1431: return HIGH_1431;
         default:  return HIGH_477;
      endcase
   endfunction

endpackage

// File: rtl/pcxt_edge_sync.sv
// Three-flop synchroniser with a registered single-cycle rising-edge pulse.
module pcxt_edge_sync
(
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic rise
);

   logic [2:0] sync_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         rise   <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
         rise   <= sync_q[1] & ~sync_q[2];
      end
   end

endmodule

// File: rtl/pcxt_clock_reset_ctrl.sv
// PCXT clock/reset controller: CPU/peripheral clock levels, speed select, splash timer, reset sequencing.
// Splash timer is built only when PCXT_SPLASH_EN is defined.
module pcxt_clock_reset_ctrl
   import pcxt_clk_pkg::*;
#(
   parameter int unsigned PRE_DIV         = 4,
   parameter int unsigned RESET_CYCLES    = 65535,
   parameter int unsigned CPU_RESET_DELAY = 42,
   parameter int unsigned TICKS_PER_SEC   = 28636000,
   parameter int unsigned SPLASH_SECONDS  = 5,
   parameter int unsigned NUM_SYNC        = 2
)
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic [1:0]          speed_sel,
   input  logic                biu_done,
   input  logic                splash_skip,
   input  logic [NUM_SYNC-1:0] async_in,
   output logic                cpu_clk,
   output logic                cpu_clk_rise,
   output logic                pclk,
   output logic                turbo_mode,
   output logic                splashscreen,
   output logic                reset_out,
   output logic                reset_cpu,
   output logic [NUM_SYNC-1:0] sync_rise
);

   localparam int unsigned PRE_W    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam int unsigned RST_MAX  = (RESET_CYCLES > CPU_RESET_DELAY) ? RESET_CYCLES : CPU_RESET_DELAY;
   localparam int unsigned CNT_W    = $clog2(RST_MAX + 1);
   localparam int unsigned SYS_LAST = (RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0;
   localparam int unsigned CPU_LAST = (CPU_RESET_DELAY > 0) ? CPU_RESET_DELAY - 1 : 0;

   // Base tick prescaler
   logic [PRE_W-1:0] pre_cnt;
   logic             tick_c;

   assign tick_c = (pre_cnt == PRE_W'(PRE_DIV - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    pre_cnt <= '0;
      else if (tick_c) pre_cnt <= '0;
      else             pre_cnt <= pre_cnt + PRE_W'(1);
   end

   // CPU phase; speed only changes at a period boundary so the high time is never cut short
   speed_t             speed, speed_d;
   logic [PHASE_W-1:0] phase, phase_d;
   logic               cpu_lvl_c;

   always_comb begin
      speed_d = speed;
      phase_d = phase;
      if (tick_c) begin
         if (phase == speed_last(speed)) begin
            phase_d = '0;
            if (biu_done) speed_d = decode_speed(speed_sel);
         end else begin
            phase_d = phase + PHASE_W'(1);
         end
      end
      cpu_lvl_c = (phase_d < speed_high(speed_d));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         speed        <= SPD_477;
         phase        <= '0;
         cpu_clk      <= 1'b0;
         cpu_clk_rise <= 1'b0;
         turbo_mode   <= 1'b0;
      end else begin
         speed        <= speed_d;
         phase        <= phase_d;
         turbo_mode   <= (speed_d != SPD_477);
         cpu_clk_rise <= tick_c & cpu_lvl_c & ~cpu_clk;
         if (tick_c) cpu_clk <= cpu_lvl_c;
      end
   end

   // Peripheral clock, fixed at 4.77 MHz / 2
   logic [PCLK_W-1:0] pclk_cnt, pclk_cnt_d;

   always_comb begin
      pclk_cnt_d = pclk_cnt;
      if (tick_c) pclk_cnt_d = (pclk_cnt == PCLK_W'(PCLK_LAST)) ? '0 : pclk_cnt + PCLK_W'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pclk_cnt <= '0;
         pclk     <= 1'b0;
      end else begin
         pclk_cnt <= pclk_cnt_d;
         if (tick_c) pclk <= (pclk_cnt_d < PCLK_W'(PCLK_HIGH));
      end
   end

   logic splash_end_c;

`ifdef PCXT_SPLASH_EN
   localparam int unsigned TPS_W       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned SEC_W       = (SPLASH_SECONDS > 0) ? $clog2(SPLASH_SECONDS + 1) : 1;
   localparam int unsigned SPLASH_LAST = (SPLASH_SECONDS > 0) ? SPLASH_SECONDS - 1 : 0;
   localparam rst_state_t  RST_INIT    = rst_state_t'((SPLASH_SECONDS == 0) ? S_SYS : S_SPLASH);

   logic [TPS_W-1:0] sec_ticks;
   logic [SEC_W-1:0] seconds;
   logic             sec_wrap_c;

   assign sec_wrap_c   = (sec_ticks == TPS_W'(TICKS_PER_SEC - 1));
   assign splash_end_c = splashscreen & tick_c &
                         (splash_skip | (sec_wrap_c & (seconds == SEC_W'(SPLASH_LAST))));

   // Counters freeze once the splash ends; splashscreen stays low until reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sec_ticks    <= '0;
         seconds      <= '0;
         splashscreen <= (SPLASH_SECONDS != 0);
      end else if (splashscreen && tick_c) begin
         if (sec_wrap_c) begin
            sec_ticks <= '0;
            seconds   <= seconds + SEC_W'(1);
         end else begin
            sec_ticks <= sec_ticks + TPS_W'(1);
         end
         if (splash_end_c) splashscreen <= 1'b0;
      end
   end
`else
   localparam rst_state_t RST_INIT = S_SYS;

   logic splash_unused_c;

   assign splash_unused_c = |{splash_skip, TICKS_PER_SEC != 0, SPLASH_SECONDS != 0};
   assign splash_end_c    = 1'b0;
   assign splashscreen    = 1'b0;
`endif

   // Reset sequencer
   rst_state_t       state, state_d;
   logic [CNT_W-1:0] rst_cnt, rst_cnt_d;
   logic             reset_out_d, reset_cpu_d;

   always_comb begin
      state_d     = state;
      rst_cnt_d   = rst_cnt;
      reset_out_d = reset_out;
      reset_cpu_d = reset_cpu;
      case (state)
         S_SPLASH: if (splash_end_c) state_d = S_SYS;
         S_SYS: begin
            if (rst_cnt == CNT_W'(SYS_LAST)) begin
               rst_cnt_d   = '0;
               reset_out_d = 1'b0;
               if (CPU_RESET_DELAY == 0) begin
                  reset_cpu_d = 1'b0;
                  state_d     = S_RUN;
               end else begin
                  state_d = S_CPU;
               end
            end else begin
               rst_cnt_d = rst_cnt + CNT_W'(1);
            end
         end
         S_CPU: begin
            if (rst_cnt == CNT_W'(CPU_LAST)) begin
               rst_cnt_d   = '0;
               reset_cpu_d = 1'b0;
               state_d     = S_RUN;
            end else begin
               rst_cnt_d = rst_cnt + CNT_W'(1);
            end
         end
         S_RUN:   ;
         default: state_d = RST_INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RST_INIT;
         rst_cnt   <= '0;
         reset_out <= 1'b1;
         reset_cpu <= 1'b1;
      end else begin
         state     <= state_d;
         rst_cnt   <= rst_cnt_d;
         reset_out <= reset_out_d;
         reset_cpu <= reset_cpu_d;
      end
   end

   for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
      pcxt_edge_sync u_edge_sync (
         .clock    (clock),
         .reset_n  (reset_n),
         .async_in (async_in[i]),
         .rise     (sync_rise[i])
      );
   end

endmodule
